ysyx_25060170_exu: RTL and testbench



---
 rtl/ysyx_25060170_exu_pkg.sv | 48 ++++
 rtl/ysyx_25060170_exu_muldiv.sv | 135 +++++++++++++
 rtl/ysyx_25060170_exu.sv | 107 ++++++++++
 tb/tb_ysyx_25060170_exu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_exu_pkg.sv
// Shared encodings for the execute stage: ALU ops, RV32M funct3, operand selects, mul/div FSM states.
// Latency: none (declarations only).
// Backpressure: none.
package ysyx_25060170_exu_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  localparam logic [1:0] SEL_A_OP1  = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [2:0] SEL_B_OP2  = 3'd0;
  localparam logic [2:0] SEL_B_IMM  = 3'd1;
  localparam logic [2:0] SEL_B_FOUR = 3'd2;

  // Operand A is signed for MULH, MULHSU, DIV, REM
  function automatic logic signed_a(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1] ^ f3[0]);
  endfunction

  // Operand B is signed for MULH, DIV, REM
  function automatic logic signed_b(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3 == M_MULH);
  endfunction

endpackage

// File: rtl/ysyx_25060170_exu_muldiv.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider on magnitudes, one bit per cycle.
// Latency: 34 cycles from start (issue, 32 CALC steps, 1 DONE cycle).
// Backpressure: busy_o holds the issuer from issue through the last CALC cycle; flush_i aborts to IDLE.
module ysyx_25060170_muldiv
  import ysyx_25060170_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, neg_r_q, neg_r_d;

  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem;
  logic [XLEN:0]   sum, shifted;
  logic [2*XLEN-1:0] prod;

  // Signs and magnitudes of the incoming operands, captured at issue
  always_comb begin
    sgn_a = a_i[XLEN-1] & signed_a(op_i);
    sgn_b = b_i[XLEN-1] & signed_b(op_i);
    mag_a = sgn_a ? -a_i : a_i;
    mag_b = sgn_b ? -b_i : b_i;
  end

  // Per-step datapath and sign-corrected final result from the accumulators
  always_comb begin
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    shifted  = {hi_q, lo_q[XLEN-1]};
    prod     = {hi_q, lo_q};
    if (neg_q) prod = -prod;
    quo      = neg_q ? -lo_q : lo_q;
    rem      = neg_r_q ? -hi_q : hi_q;
    result_o = '0;
    if (op_q[2]) result_o = op_q[1] ? rem : quo;
    else         result_o = (op_q == M_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // FSM next state, iteration update and status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    neg_d   = neg_q;
    neg_r_d = neg_r_q;
    idle_o  = (state_q == MD_IDLE);
    busy_o  = ((state_q == MD_IDLE) && start_i) || (state_q == MD_CALC);
    done_o  = (state_q == MD_DONE);
    if (flush_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_d = MD_CALC;
            cnt_d   = '0;
            hi_d    = '0;
            op_d    = op_i;
            neg_d   = sgn_a ^ sgn_b;
            neg_r_d = sgn_a;
            // Divider shifts the dividend out of lo; multiplier consumes the multiplier from lo
            if (op_i[2]) begin
              lo_d  = mag_a;
              dvs_d = mag_b;
            end else begin
              lo_d  = mag_b;
              dvs_d = mag_a;
            end
          end
        end
        MD_CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (op_q[2]) begin
            if (shifted >= {1'b0, dvs_q}) begin
              hi_d = shifted[XLEN-1:0] - dvs_q;
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = shifted[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == 5'd31) state_d = MD_DONE;
        end
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      neg_r_q <= neg_r_d;
    end
  end

endmodule

// File: rtl/ysyx_25060170_exu.sv
// Execute stage: operand muxes, single-cycle RV32I ALU, divide corner cases, iterative RV32M unit.
// Latency: ALU and divide corner cases 0 cycles; other M-ops 34 cycles including issue.
// Backpressure: ex_ready (combinational) stalls the ID/EX register while an M-op is issuing or iterating.
module ysyx_25060170_exu
  import ysyx_25060170_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [1:0]      ex_op1_sel,
  input  logic [2:0]      ex_op2_sel,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [7:0]      ex_alusrc,
  input  logic            ex_rd_ena,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_flush,
  output logic            ex_ready,
  output logic            exu_valid,
  output logic [XLEN-1:0] exu_result,
  output logic [XLEN-1:0] exu_store_data,
  output logic            exu_rd_ena,
  output logic [4:0]      exu_rd_addr
);

  logic [XLEN-1:0] src_a, src_b, alu_res, special_res, md_result;
  logic [2:0]      f3;
  logic            is_m, div_zero, div_ovf, is_special;
  logic            md_start, md_idle, md_busy, md_done;
  logic            unused_alusrc;

  assign is_m          = ex_alusrc[7];
  assign f3            = ex_alusrc[2:0];
  assign unused_alusrc = ^ex_alusrc[6:4];

  // Operand source selection
  always_comb begin
    src_a = '0;
    src_b = '0;
    case (ex_op1_sel)
      SEL_A_OP1: src_a = ex_op1;
      SEL_A_PC:  src_a = ex_pc;
      default:   src_a = '0;
    endcase
    case (ex_op2_sel)
      SEL_B_OP2:  src_b = ex_op2;
      SEL_B_IMM:  src_b = ex_imm;
      SEL_B_FOUR: src_b = XLEN'(4);
      default:    src_b = '0;
    endcase
  end

  // Single-cycle ALU; unused op codes yield zero
  always_comb begin
    alu_res = '0;
    case (ex_alusrc[3:0])
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLL:  alu_res = src_a << src_b[4:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SRL:  alu_res = src_a >> src_b[4:0];
      ALU_SRA:  alu_res = $signed(src_a) >>> src_b[4:0];
      ALU_OR:   alu_res = src_a | src_b;
      ALU_AND:  alu_res = src_a & src_b;
      default:  alu_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow are answered directly, never entering the iterative unit
  always_comb begin
    div_zero    = f3[2] & (src_b == '0);
    div_ovf     = f3[2] & ~f3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
    is_special  = is_m & (div_zero | div_ovf);
    special_res = '0;
    if (div_zero)     special_res = f3[1] ? src_a : '1;
    else if (div_ovf) special_res = f3[1] ? '0 : src_a;
  end

  assign md_start = is_m & ~is_special & ~ex_flush;

  ysyx_25060170_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .flush_i  (ex_flush),
    .op_i     (f3),
    .a_i      (src_a),
    .b_i      (src_b),
    .idle_o   (md_idle),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign ex_ready       = md_busy & ~ex_flush;
  assign exu_valid      = ~ex_flush & ((md_idle & (~is_m | is_special)) | md_done);
  assign exu_result     = md_done ? md_result : (is_m ? special_res : alu_res);
  assign exu_store_data = ex_op2;
  assign exu_rd_ena     = ex_rd_ena & exu_valid;
  assign exu_rd_addr    = ex_rd_addr;

endmodule

// File: tb/tb_ysyx_25060170_exu.sv
// Self-checking bench for ysyx_25060170_exu: directed vector table, flush/reset sequences, random ops vs model.
// Latency: n/a.
// Backpressure: waits on exu_valid with a bounded cycle budget.
module tb_ysyx_25060170_exu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [1:0]  ex_op1_sel;
  logic [2:0]  ex_op2_sel;
  logic [7:0]  ex_alusrc;
  logic        ex_rd_ena, ex_flush;
  logic [4:0]  ex_rd_addr;
  logic        ex_ready, exu_valid, exu_rd_ena;
  logic [31:0] exu_result, exu_store_data;
  logic [4:0]  exu_rd_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25060170_exu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_op1_sel(ex_op1_sel), .ex_op2_sel(ex_op2_sel), .ex_imm(ex_imm), .ex_alusrc(ex_alusrc),
    .ex_rd_ena(ex_rd_ena), .ex_rd_addr(ex_rd_addr), .ex_flush(ex_flush),
    .ex_ready(ex_ready), .exu_valid(exu_valid), .exu_result(exu_result),
    .exu_store_data(exu_store_data), .exu_rd_ena(exu_rd_ena), .exu_rd_addr(exu_rd_addr)
  );

  typedef struct {
    logic [1:0]  s1;
    logic [2:0]  s2;
    logic [31:0] a, b, imm, pc;
    logic [7:0]  src;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] s1, input logic [2:0] s2, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [7:0] src, input logic [31:0] exp, input int lat);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.src = src; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] mux_a(input logic [1:0] s, input logic [31:0] op1, input logic [31:0] pc);
    if (s == 2'd0) return op1;
    if (s == 2'd1) return pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] mux_b(input logic [2:0] s, input logic [31:0] op2, input logic [31:0] imm);
    if (s == 3'd0) return op2;
    if (s == 3'd1) return imm;
    if (s == 3'd2) return 32'd4;
    return 32'd0;
  endfunction

  function automatic logic is_spec(input logic [31:0] a, input logic [31:0] b, input logic [7:0] src);
    if (!src[7] || !src[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return !src[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [7:0] src);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (src[7]) begin
      case (src[2:0])
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * ub; return p[63:32]; end
        3'd3: begin p = ua * ub; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          if (is_spec(a, b, src)) return a;
          return 32'(sa / sb);
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
        3'd6: begin
          if (b == 0) return a;
          if (is_spec(a, b, src)) return 32'd0;
          return 32'(sa % sb);
        end
        default: return (b == 0) ? a : 32'(ua % ub);
      endcase
    end
    case (src[3:0])
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return 32'(ua << b[4:0]);
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return (ua < ub) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return 32'(ua >> b[4:0]);
      4'd7: return 32'(sa >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [7:0] src);
    return (src[7] && !is_spec(a, b, src)) ? 33 : 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic [1:0] s1, input logic [2:0] s2, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [7:0] src,
                       input logic rde, input logic [4:0] rda);
    ex_op1_sel = s1; ex_op2_sel = s2; ex_op1 = a; ex_op2 = b; ex_imm = imm; ex_pc = pc;
    ex_alusrc = src; ex_rd_ena = rde; ex_rd_addr = rda;
  endtask

  // Issue one bundle and follow it to exu_valid, checking latency, stall span and outputs
  task automatic run(input string nm, input vec_t v);
    int         rdy, got;
    logic       rde;
    logic [4:0] rda;
    rde = 1'($urandom_range(0, 1));
    rda = 5'($urandom_range(0, 31));
    @(posedge clk); #1;
    drive(v.s1, v.s2, v.a, v.b, v.imm, v.pc, v.src, rde, rda);
    rdy = 0;
    got = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (exu_valid) begin
        got = c;
        break;
      end
      if (ex_ready) rdy++;
    end
    check({nm, "/latency"}, 32'(got), 32'(v.lat));
    check({nm, "/stall_cycles"}, 32'(rdy), 32'(v.lat));
    if (got >= 0) begin
      check({nm, "/result"}, exu_result, v.exp);
      check({nm, "/ready_at_valid"}, {31'd0, ex_ready}, 32'd0);
      check({nm, "/rd"}, {26'd0, exu_rd_ena, exu_rd_addr}, {26'd0, rde, rda});
      check({nm, "/store"}, exu_store_data, v.b);
    end
  endtask

  vec_t vt[25];

  initial begin
    int v;
    vec_t r;

    vt[0]  = mk(2'd0, 3'd1, 32'd5, 32'd0, 32'd7, 32'd0, 8'h00, 32'd12, 0);
    vt[1]  = mk(2'd0, 3'd0, 32'd10, 32'd3, 32'd0, 32'd0, 8'h01, 32'd7, 0);
    vt[2]  = mk(2'd0, 3'd0, 32'd1, 32'd35, 32'd0, 32'd0, 8'h02, 32'd8, 0);
    vt[3]  = mk(2'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 8'h03, 32'd1, 0);
    vt[4]  = mk(2'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 8'h04, 32'd0, 0);
    vt[5]  = mk(2'd0, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 8'h05, 32'h0FF0_0FF0, 0);
    vt[6]  = mk(2'd0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 8'h06, 32'h0800_0000, 0);
    vt[7]  = mk(2'd0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 8'h07, 32'hF800_0000, 0);
    vt[8]  = mk(2'd0, 3'd0, 32'h0F, 32'hF0, 32'd0, 32'd0, 8'h08, 32'hFF, 0);
    vt[9]  = mk(2'd0, 3'd0, 32'h3C, 32'h0F, 32'd0, 32'd0, 8'h09, 32'h0C, 0);
    vt[10] = mk(2'd0, 3'd0, 32'd5, 32'd6, 32'd0, 32'd0, 8'h0C, 32'd0, 0);
    vt[11] = mk(2'd1, 3'd2, 32'd0, 32'd0, 32'd0, 32'h8000_0010, 8'h00, 32'h8000_0014, 0);
    vt[12] = mk(2'd2, 3'd1, 32'd99, 32'd0, 32'hFFFF_F800, 32'd0, 8'h00, 32'hFFFF_F800, 0);
    vt[13] = mk(2'd0, 3'd5, 32'h1234, 32'd77, 32'd0, 32'd0, 8'h00, 32'h1234, 0);
    vt[14] = mk(2'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 8'h81, 32'hFFFF_FFFF, 33);
    vt[15] = mk(2'd0, 3'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 8'h84, 32'hFFFF_FFFD, 33);
    vt[16] = mk(2'd0, 3'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 8'h86, 32'hFFFF_FFFF, 33);
    vt[17] = mk(2'd0, 3'd0, 32'd9, 32'd0, 32'd0, 32'd0, 8'h85, 32'hFFFF_FFFF, 0);
    vt[18] = mk(2'd0, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'h84, 32'h8000_0000, 0);
    vt[19] = mk(2'd0, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'h86, 32'd0, 0);
    vt[20] = mk(2'd0, 3'd0, 32'd9, 32'd0, 32'd0, 32'd0, 8'h87, 32'd9, 0);
    vt[21] = mk(2'd0, 3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 8'h80, 32'd42, 33);
    vt[22] = mk(2'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'h83, 32'hFFFF_FFFE, 33);
    vt[23] = mk(2'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'h82, 32'hFFFF_FFFF, 33);
    vt[24] = mk(2'd0, 3'd0, 32'd100, 32'd7, 32'd0, 32'd0, 8'h85, 32'd14, 33);

    // Reset state with all-zero inputs
    rst = 1'b1;
    ex_flush = 1'b0;
    drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/ready", {31'd0, ex_ready}, 32'd0);
    check("reset/valid", {31'd0, exu_valid}, 32'd1);
    check("reset/result", exu_result, 32'd0);
    check("reset/rd_ena", {31'd0, exu_rd_ena}, 32'd0);
    rst = 1'b0;

    // Directed vectors, issued back to back
    for (int i = 0; i < 25; i++) run($sformatf("vec%0d", i), vt[i]);

    // Flush at cycle 10 of a DIVU: no valid, no stall, then an ADD completes
    @(posedge clk); #1;
    drive(2'd0, 3'd0, 32'd100, 32'd7, 32'd0, 32'd0, 8'h85, 1'b1, 5'd3);
    v = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (exu_valid) v++;
    end
    @(posedge clk); #1;
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush/ready", {31'd0, ex_ready}, 32'd0);
    check("flush/valid", {31'd0, exu_valid}, 32'd0);
    check("flush/early_valid", 32'(v), 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0;
    drive(2'd0, 3'd1, 32'd3, 32'd0, 32'd4, 32'd0, 8'h00, 1'b1, 5'd9);
    @(negedge clk);
    check("flush/add_valid", {31'd0, exu_valid}, 32'd1);
    check("flush/add_result", exu_result, 32'd7);
    check("flush/add_ready", {31'd0, ex_ready}, 32'd0);

    // Flush landing on the DONE cycle suppresses the result
    @(posedge clk); #1;
    drive(2'd0, 3'd0, 32'd6, 32'd7, 32'd0, 32'd0, 8'h80, 1'b1, 5'd4);
    repeat (33) @(posedge clk);
    #1 ex_flush = 1'b1;
    @(negedge clk);
    check("flush_done/valid", {31'd0, exu_valid}, 32'd0);
    check("flush_done/rd_ena", {31'd0, exu_rd_ena}, 32'd0);
    @(posedge clk); #1;
    ex_flush = 1'b0;
    drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 1'b0, 5'd0);

    // Reset in the middle of CALC
    @(posedge clk); #1;
    drive(2'd0, 3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 8'h80, 1'b1, 5'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 1'b0, 5'd0);
    @(negedge clk);
    check("rst_calc/ready_before", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_calc/ready", {31'd0, ex_ready}, 32'd0);
    check("rst_calc/valid", {31'd0, exu_valid}, 32'd1);
    check("rst_calc/result", exu_result, 32'd0);
    rst = 1'b0;
    run("rst_calc/mul_after", mk(2'd0, 3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 8'h80, 32'd15, 33));

    // Random bundles against the model
    for (int i = 0; i < 50; i++) begin
      r.s1  = 2'($urandom_range(0, 3));
      r.s2  = 3'($urandom_range(0, 7));
      r.a   = pick();
      r.b   = pick();
      r.imm = pick();
      r.pc  = $urandom;
      if ($urandom_range(0, 1) == 1) r.src = {5'b10000, 3'($urandom_range(0, 7))};
      else                           r.src = {4'b0000, 4'($urandom_range(0, 15))};
      r.exp = ref_res(mux_a(r.s1, r.a, r.pc), mux_b(r.s2, r.b, r.imm), r.src);
      r.lat = ref_lat(mux_a(r.s1, r.a, r.pc), mux_b(r.s2, r.b, r.imm), r.src);
      run($sformatf("rnd%0d", i), r);
    end

    @(posedge clk); #1;
    drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 1'b0, 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
